alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle integer execution unit for the RV32IM datapath. Executes the ten RV32I ALU operations with one-cycle registered latency and the eight M-extension operations (multiply and divide families) iteratively over XLEN cycles. Operands enter through a valid/ready handshake and results leave through a second one, so the pipeline can stall on long operations. It replaces the purely combinational ALU in the execute stage wherever M-extension support is built.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8 and a power of two.
- SHW, $clog2(XLEN): shift-amount width; derived, not overridden.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; returns to IDLE, discards the operation in flight.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2/imm).
- alu_sel  in  5  op select (encodings below).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0, derived from the registered result.

## Operation
- Encodings: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT, 00110 SLTU, 00111 SLL, 01000 SRL, 01001 SRA; 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; any other code gives result 0 on the single-cycle path.
- Shifts use b[SHW-1:0]. SLT/SLTU produce 1 or 0, zero-extended.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid, operands, op and operand signs are latched.
  - Base op, illegal code, or divide special case: result computed and registered, next state DONE.
  - Other M op: next state BUSY, iteration counter = 0.
- BUSY: one iteration per cycle for XLEN cycles.
  - Multiply: shift-add on operand magnitudes into a 2·XLEN accumulator. The sign is applied at the end: MUL/MULH treat both operands as signed, MULHSU treats a signed and b unsigned, MULHU treats both unsigned.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - Divide: restoring division on magnitudes. The quotient is negated when the operand signs differ (signed ops only). The remainder takes the sign of the dividend.
  - After iteration XLEN-1, the final result is registered and the state goes to DONE.
- DONE: out_valid=1, and result and zero stay stable. When out_ready=1 the state goes to IDLE and out_valid drops in the next cycle.
- Divide special cases, resolved in IDLE without entering BUSY:
  - b=0: DIV/DIVU give all-ones; REM/REMU give a.
  - DIV with a = most-negative value and b = all-ones gives a; REM with the same operands gives 0.
- flush has priority over every transition except rst. It forces IDLE, clears out_valid, and leaves result unchanged.
- in_valid while not in IDLE is ignored, because in_ready=0.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, counter 0.
- Latency, measured from the accept edge to the first cycle with out_valid=1:
  - Base op, illegal code, or divide special case: 1 cycle.
  - Multiply/divide: XLEN+1 cycles (33 at XLEN=32).
- Throughput: at best one base op every 2 cycles. Accept and drain never happen in the same cycle.
- out_ready held low in DONE: the unit holds indefinitely with no change on any output.
- rst asserted mid-BUSY: immediate return to the reset values listed above. No partial result appears.
- flush and in_valid in the same IDLE cycle: nothing is accepted.

## Test plan
- ADD 0x7FFFFFFF + 1 -> 0x80000000 one cycle after accept. SUB 5-5 -> 0 with zero=1. SRA 0x80000000 by b=0x24 (shift uses 4) -> 0xF8000000.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0. MULHU with the same operands -> 0xFFFFFFFE. MUL 0xFFFF × 0x10001 -> 0xFFFFFFFF. Each has out_valid exactly 33 cycles after accept.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide special cases, each with out_valid after 1 cycle:
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles in DONE: result stays stable and in_ready stays 0.
  - Pulse flush in BUSY cycle 10: IDLE next cycle, out_valid never rises, and the next ADD completes correctly.
- Assert rst in BUSY cycle 5 of DIVU: out_valid=0, result=0 and in_ready=1 immediately. A subsequent ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32IM integer execution unit.
// Base ALU ops (and illegal codes / divide special cases) complete with one
// registered cycle; the M-extension multiply and divide families run
// iteratively for XLEN cycles on operand magnitudes, with signs fixed up at
// the end.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   flush           synchronous abort back to IDLE (result left unchanged)
//   in_valid/ready  operand handshake (ready only in IDLE)
//   a, b, alu_sel   operands and 5-bit op select
//   out_valid/ready result handshake (valid held until accepted)
//   result, zero    registered result and result==0 flag
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      alu_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_AND    = 5'b00010;
  localparam logic [4:0] OP_OR     = 5'b00011;
  localparam logic [4:0] OP_XOR    = 5'b00100;
  localparam logic [4:0] OP_SLT    = 5'b00101;
  localparam logic [4:0] OP_SLTU   = 5'b00110;
  localparam logic [4:0] OP_SLL    = 5'b00111;
  localparam logic [4:0] OP_SRL    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_REM    = 5'b10110;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // ---------------- single-cycle path ----------------
  logic [XLEN-1:0] base_res;
  always_comb begin
    base_res = '0;
    case (alu_sel)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL:  base_res = a << b[SHW-1:0];
      OP_SRL:  base_res = a >> b[SHW-1:0];
      OP_SRA:  base_res = $signed(a) >>> b[SHW-1:0];
      default: base_res = '0;
    endcase
  end

  // ---------------- M-extension operand preparation ----------------
  logic is_m, is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, spec_res;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (alu_sel)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_MULHSU:                       sgn_a = 1'b1;
      default:                         ;
    endcase
  end

  assign is_m     = (alu_sel[4:3] == 2'b10);
  assign is_div   = is_m & alu_sel[2];
  assign neg_a    = sgn_a & a[XLEN-1];
  assign neg_b    = sgn_b & b[XLEN-1];
  assign mag_a    = neg_a ? -a : a;
  assign mag_b    = neg_b ? -b : b;
  assign div_zero = (b == '0);
  // Signed overflow only for DIV/REM (bit 0 clear).
  assign div_ovf  = (a == MOST_NEG) && (b == '1) && !alu_sel[0];

  always_comb begin
    spec_res = '0;
    if (div_zero) spec_res = alu_sel[1] ? a : '1;
    else          spec_res = alu_sel[1] ? '0 : a;
  end

  // ---------------- iteration step ----------------
  // Multiply: accumulator high half gathers partial sums, low half holds the
  // remaining multiplier bits; shift right one place per step.
  // Divide: accumulator high half is the partial remainder, low half shifts
  // the dividend out and the quotient bits in.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod;
  logic [XLEN-1:0]   mul_res, div_res, fin_res, quo, rmd;
  logic              sgn_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? m_q : '0)};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_sh - {1'b0, m_q};
    div_ge    = !div_diff[XLEN];
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                 acc_q[XLEN-2:0], div_ge};
    step_next = op_q[2] ? div_next : mul_next;

    sgn_diff  = neg_a_q ^ neg_b_q;
    prod      = sgn_diff ? -mul_next : mul_next;
    mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo       = div_next[XLEN-1:0];
    rmd       = div_next[2*XLEN-1:XLEN];
    div_res   = op_q[1] ? (neg_a_q ? -rmd : rmd) : (sgn_diff ? -quo : quo);
    fin_res   = op_q[2] ? div_res : mul_res;
  end

  // ---------------- control ----------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_d    = alu_sel[2:0];
          neg_a_d = neg_a;
          neg_b_d = neg_b;
          if (!is_m) begin
            result_d = base_res;
            state_d  = DONE;
          end else if (is_div && (div_zero || div_ovf)) begin
            result_d = spec_res;
            state_d  = DONE;
          end else begin
            m_d     = is_div ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          acc_d = step_next;
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == SHW'(XLEN-1)) begin
            result_d = fin_res;
            cnt_d    = '0;
            state_d  = DONE;
          end
        end
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [XLEN-1:0] a, b, result;
  logic [4:0]      alu_sel;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_sel(alu_sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   ov_rises = 0;
  logic prev_ov  = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge, notes accepts, and checks each
  // result the first cycle out_valid is presented.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (in_valid && in_ready && !flush && !rst) acc_cyc = cyc;
    if (out_valid && !prev_ov) begin
      ov_rises++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got result 0x%08h expected no output", result);
      end else begin
        e = sb.pop_front();
        check({e.name, " result"}, result, e.res);
        check({e.name, " zero"}, 32'(zero), 32'(e.res == 32'h0));
        check({e.name, " latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
    prev_ov = out_valid;
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] res, input int lat,
                       input bit track);
    int k;
    for (k = 0; k < 200 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s issue_timeout: got in_ready=0 expected 1", name);
    end
    if (track) sb.push_back('{name, res, lat});
    alu_sel  = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !out_valid && in_ready) break;
      @(posedge clk); #1;
    end
    if (k == 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s drain_timeout: got pending=%0d expected 0", name, sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rises;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_sel = '0;

    vecs.push_back('{"ADD",     5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1});
    vecs.push_back('{"SUB",     5'b00001, 32'd5,        32'd5,        32'h00000000, 1});
    vecs.push_back('{"SRA",     5'b01001, 32'h80000000, 32'h00000024, 32'hF8000000, 1});
    vecs.push_back('{"SLT",     5'b00101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
    vecs.push_back('{"SLTU",    5'b00110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{"SLL",     5'b00111, 32'h00000001, 32'h0000003F, 32'h80000000, 1});
    vecs.push_back('{"ILLEGAL", 5'b01111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1});
    vecs.push_back('{"MULH",    5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    vecs.push_back('{"MULHU",   5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    vecs.push_back('{"MUL",     5'b10000, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 33});
    vecs.push_back('{"MULHSU",  5'b10010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{"DIV",     5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    vecs.push_back('{"REM",     5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{"DIVU",    5'b10101, 32'd100,      32'd7,        32'd14,       33});
    vecs.push_back('{"REMU",    5'b10111, 32'd100,      32'd7,        32'd2,        33});
    vecs.push_back('{"DIV_OVF", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"REM_OVF", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{"DIVU_Z",  5'b10101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"REM_Z",   5'b10110, 32'd5,        32'd0,        32'd5,        1});

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'h0);
    check("reset zero", 32'(zero), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].lat, 1'b1);
      wait_idle(vecs[i].name);
    end

    // Backpressure: hold the result in DONE for 10 cycles.
    out_ready = 1'b0;
    issue("BP_ADD", 5'b00000, 32'd10, 32'd20, 32'd30, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp result", result, 32'd30);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    wait_idle("BP_ADD");

    // Flush in BUSY cycle 10 of a multiply.
    issue("FLUSH_MULHU", 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush in_ready", 32'(in_ready), 32'd1);
    check("flush out_valid", 32'(out_valid), 32'd0);
    rises = ov_rises;
    repeat (40) @(posedge clk);
    #1;
    check("flush no out_valid", 32'(ov_rises), 32'(rises));
    check("flush result kept", result, 32'd30);
    issue("POST_FLUSH_ADD", 5'b00000, 32'd1, 32'd1, 32'd2, 1, 1'b1);
    wait_idle("POST_FLUSH_ADD");

    // flush together with in_valid in IDLE: nothing accepted.
    alu_sel = 5'b00000; a = 32'd7; b = 32'd8;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle in_ready", 32'(in_ready), 32'd1);
    check("flush_idle out_valid", 32'(out_valid), 32'd0);

    // Reset in BUSY cycle 5 of DIVU.
    issue("RST_DIVU", 5'b10101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'h0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue("POST_RST_ADD", 5'b00000, 32'd2, 32'd3, 32'd5, 1, 1'b1);
    wait_idle("POST_RST_ADD");

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
